// File: rtl/flight_pkg.sv
// Flight constants shared by the ascent integrator and the gimbal controller:
// phase encoding and the fixed-point scale (1 LSB = 1e-9 m).
package flight_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_BURN   = 2'd1,
    PH_COAST  = 2'd2,
    PH_LANDED = 2'd3
  } phase_e;

  localparam logic [63:0] FX_SCALE = 64'd1_000_000_000;
  localparam logic [63:0] ALT_30KM = 64'd30_000 * FX_SCALE;

endpackage

// File: rtl/sat_add.sv
// Signed adder whose result saturates symmetrically at +/-(2^(DATA_W-1)-1).
module sat_add #(
  parameter int DATA_W = 64
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] sum
);

  localparam logic signed [DATA_W:0] POS_LIM = (DATA_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [DATA_W:0] NEG_LIM = -POS_LIM;

  logic signed [DATA_W:0] wide;

  always_comb begin
    wide = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    if (wide > POS_LIM) begin
      sum = POS_LIM[DATA_W-1:0];
    end else if (wide < NEG_LIM) begin
      sum = NEG_LIM[DATA_W-1:0];
    end else begin
      sum = wide[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ascent_integrator.sv
// Ascent integrator: semi-implicit Euler velocity/height with an IDLE/BURN/COAST/LANDED phase FSM.
// Define ASCENT_APOGEE_EN to build the apogee detector; otherwise apogee outputs are tied to zero.
module ascent_integrator
  import flight_pkg::*;
#(
  parameter int N           = 64,
  parameter int G_ACCEL     = 10,
  parameter int BURN_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         start,
  input  logic [N-1:0] thrust_accel,
  output logic [N-1:0] velocity,
  output logic [N-1:0] height,
  output logic         step,
  output logic [1:0]   phase,
  output logic         above_30km,
  output logic         apogee,
  output logic [N-1:0] apogee_height
);

  localparam int                    CNT_W    = $clog2(BURN_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BURN_CYCLES - 1);
  localparam logic signed [N-1:0]   G_S      = N'(G_ACCEL);
  localparam logic signed [N+1:0]   V_MAX_W  = (N+2)'({1'b0, {(N-1){1'b1}}});
  localparam logic signed [N+1:0]   H_MAX_W  = (N+2)'({N{1'b1}});
  localparam logic [N-1:0]          ALT_N    = N'(ALT_30KM);

  // Thrust is unsigned and may exceed the signed range; clamp the net acceleration term.
  function automatic logic signed [N-1:0] sat_burn_accel(input logic [N-1:0] thrust);
    logic signed [N+1:0] d;
    d = $signed({2'b00, thrust}) - (N+2)'(G_S);
    if (d > V_MAX_W) begin
      return V_MAX_W[N-1:0];
    end
    return d[N-1:0];
  endfunction

  function automatic logic [N-1:0] clamp_height(input logic signed [N+1:0] s);
    if (s[N+1]) begin
      return '0;
    end
    if (s > H_MAX_W) begin
      return '1;
    end
    return s[N-1:0];
  endfunction

  phase_e                state;
  phase_e                state_n;
  logic signed [N-1:0]   vel_p1;
  logic [N-1:0]          hgt_p1;
  logic [CNT_W-1:0]      cnt_p1;
  logic                  vld_p1;
  logic                  above_p1;

  logic signed [N-1:0]   accel;
  logic signed [N-1:0]   v_next;
  logic signed [N-1:0]   v_new;
  logic signed [N+1:0]   h_ext;
  logic signed [N+1:0]   v_ext;
  logic signed [N+1:0]   h_sum;
  logic [N-1:0]          h_new;
  logic                  upd;
  logic                  clr;
  logic                  burn_last;
  logic                  on_pad;
  logic                  touchdown;
  logic                  zero_out;

  // Stage p0: combinational integration from the current registered state
  assign accel = (state == PH_BURN) ? sat_burn_accel(thrust_accel) : -G_S;

  sat_add #(.DATA_W(N)) u_vel_add (
    .a   (vel_p1),
    .b   (accel),
    .sum (v_next)
  );

  // Two guard bits keep the height sum exact, so over/underflow is judged afterwards.
  assign h_ext = $signed({2'b00, hgt_p1});
  assign v_ext = (N+2)'(v_next);

  sat_add #(.DATA_W(N+2)) u_hgt_add (
    .a   (h_ext),
    .b   (v_ext),
    .sum (h_sum)
  );

  assign burn_last = (cnt_p1 == CNT_LAST);
  assign on_pad    = h_sum[N+1];
  assign touchdown = h_sum[N+1] || (h_sum == '0);
  assign zero_out  = (state == PH_BURN) ? on_pad : touchdown;
  assign v_new     = zero_out ? '0 : v_next;
  assign h_new     = zero_out ? '0 : clamp_height(h_sum);

  always_comb begin
    state_n = state;
    upd     = 1'b0;
    clr     = 1'b0;
    case (state)
      PH_IDLE, PH_LANDED: begin
        if (start) begin
          state_n = PH_BURN;
          clr     = 1'b1;
        end
      end
      PH_BURN: begin
        upd = 1'b1;
        if (burn_last) begin
          state_n = PH_COAST;
        end
      end
      PH_COAST: begin
        upd = 1'b1;
        if (touchdown) begin
          state_n = PH_LANDED;
        end
      end
      default: state_n = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= PH_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Stage p1: registered flight state, valid pulse and altitude flag
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      vel_p1   <= '0;
      hgt_p1   <= '0;
      cnt_p1   <= '0;
      vld_p1   <= 1'b0;
      above_p1 <= 1'b0;
    end else begin
      vld_p1 <= upd;
      if (clr) begin
        vel_p1   <= '0;
        hgt_p1   <= '0;
        cnt_p1   <= '0;
        above_p1 <= 1'b0;
      end else if (upd) begin
        vel_p1   <= v_new;
        hgt_p1   <= h_new;
        above_p1 <= (h_new >= ALT_N);
        if (state == PH_BURN) begin
          cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
      end
    end
  end

`ifdef ASCENT_APOGEE_EN
  logic         apo_hit;
  logic         apo_p1;
  logic [N-1:0] apo_h_p1;

  // Apogee is the coast update where velocity goes from positive to non-positive.
  assign apo_hit = (state == PH_COAST) && !vel_p1[N-1] && (vel_p1 != '0)
                   && (v_next[N-1] || (v_next == '0));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      apo_p1   <= 1'b0;
      apo_h_p1 <= '0;
    end else begin
      apo_p1 <= apo_hit;
      if (clr) begin
        apo_h_p1 <= '0;
      end else if (apo_hit) begin
        apo_h_p1 <= h_new;
      end
    end
  end

  assign apogee        = apo_p1;
  assign apogee_height = apo_h_p1;
`else
  assign apogee        = 1'b0;
  assign apogee_height = '0;
`endif

  assign velocity   = vel_p1;
  assign height     = hgt_p1;
  assign step       = vld_p1;
  assign phase      = state;
  assign above_30km = above_p1;

endmodule

// File: tb/tb_ascent_integrator.sv
// Self-checking bench for ascent_integrator against a per-update flight model.
`timescale 1ns/1ps
module tb_ascent_integrator;

  localparam int N  = 64;
  localparam int G  = 10;
  localparam int BC = 4;
`ifdef ASCENT_APOGEE_EN
  localparam bit APO_EN = 1'b1;
`else
  localparam bit APO_EN = 1'b0;
`endif

  localparam logic signed [127:0] GS   = 128'(G);
  localparam logic signed [127:0] VMAX = (128'sd1 <<< 63) - 128'sd1;
  localparam logic signed [127:0] HMAX = (128'sd1 <<< 64) - 128'sd1;
  localparam logic signed [127:0] ALT  = 128'sd30_000_000_000_000;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] thrust_accel = '0;
  logic [N-1:0] velocity;
  logic [N-1:0] height;
  logic         step;
  logic [1:0]   phase;
  logic         above_30km;
  logic         apogee;
  logic [N-1:0] apogee_height;

  int checks = 0;
  int errors = 0;
  int h_tab[4] = '{100, 300, 600, 1000};

  logic [3*N+4:0] obs;
  assign obs = {velocity, height, phase, step, above_30km, apogee, apogee_height};

  ascent_integrator #(.N(N), .G_ACCEL(G), .BURN_CYCLES(BC)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .start         (start),
    .thrust_accel  (thrust_accel),
    .velocity      (velocity),
    .height        (height),
    .step          (step),
    .phase         (phase),
    .above_30km    (above_30km),
    .apogee        (apogee),
    .apogee_height (apogee_height)
  );

  always #5 clk = ~clk;

  // Reference flight state, in wide signed integers
  int                 m_phase;
  int                 m_cnt;
  logic signed [127:0] m_v;
  logic signed [127:0] m_h;
  logic signed [127:0] m_apoh;
  logic               m_step;
  logic               m_above;
  logic               m_apo;

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_v = 0; m_h = 0; m_apoh = 0;
    m_step = 0; m_above = 0; m_apo = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] thr, input logic st);
    logic signed [127:0] vn;
    logic signed [127:0] hn;
    int ph;
    logic apo_now;
    ph = m_phase;
    m_step = 0;
    m_apo = 0;
    if (ph == 0 || ph == 3) begin
      if (st) begin
        m_phase = 1; m_cnt = 0; m_v = 0; m_h = 0; m_above = 0; m_apoh = 0;
      end
    end else begin
      m_step = 1;
      if (ph == 1) vn = m_v + $signed({64'd0, thr}) - GS;
      else         vn = m_v - GS;
      if (vn > VMAX)  vn = VMAX;
      if (vn < -VMAX) vn = -VMAX;
      hn = m_h + vn;
      apo_now = APO_EN && (ph == 2) && (m_v > 0) && (vn <= 0);
      if (ph == 1) begin
        if (hn < 0) begin vn = 0; hn = 0; end
        m_cnt++;
        if (m_cnt == BC) m_phase = 2;
      end else begin
        if (hn <= 0) begin vn = 0; hn = 0; m_phase = 3; end
        else if (hn > HMAX) hn = HMAX;
      end
      m_v = vn;
      m_h = hn;
      m_above = (hn >= ALT);
      if (apo_now) begin
        m_apo = 1;
        m_apoh = hn;
      end
    end
  endtask

  function automatic logic [3*N+4:0] model_word();
    return {m_v[N-1:0], m_h[N-1:0], m_phase[1:0], m_step, m_above, m_apo, m_apoh[N-1:0]};
  endfunction

  task automatic tick(input logic [N-1:0] thr, input logic st);
    thrust_accel = thr;
    start = st;
    @(posedge clk);
    model_edge(thr, st);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_state: got %h required 0", obs);
    end
    @(negedge clk);
    resetb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick('0, 1'b0);
      checks++;
      if (obs !== model_word()) begin
        errors++; $display("FAIL idle_hold %0d: got %h required %h", i, obs, model_word());
      end
    end
  endtask

  task automatic test_nominal();
    int apo_cnt;
    apo_cnt = 0;
    tick('0, 1'b1);
    checks++;
    if (phase !== 2'd1 || step !== 1'b0 || velocity !== '0 || height !== '0) begin
      errors++; $display("FAIL start_to_burn: got ph=%0d step=%0b v=%0d h=%0d required ph=1 step=0 v=0 h=0",
                         phase, step, velocity, height);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(64'd110, 1'b0);
      checks++;
      if (velocity !== 64'(100 * k) || height !== 64'(h_tab[k-1]) || step !== 1'b1) begin
        errors++; $display("FAIL nominal_burn %0d: got v=%0d h=%0d step=%0b required v=%0d h=%0d step=1",
                           k, velocity, height, step, 100 * k, h_tab[k-1]);
      end
      checks++;
      if (obs !== model_word()) begin
        errors++; $display("FAIL nominal_burn_model %0d: got %h required %h", k, obs, model_word());
      end
    end
    checks++;
    if (phase !== 2'd2) begin
      errors++; $display("FAIL coast_entry: got phase %0d required 2", phase);
    end
    for (int i = 1; i <= 40; i++) begin
      tick('0, i == 10);
      if (apogee === 1'b1) apo_cnt++;
      checks++;
      if (obs !== model_word()) begin
        errors++; $display("FAIL coast_model %0d: got %h required %h", i, obs, model_word());
      end
      if (i == 1) begin
        checks++;
        if ($signed(velocity) !== 64'sd390 || height !== 64'd1390) begin
          errors++; $display("FAIL first_coast: got v=%0d h=%0d required v=390 h=1390",
                             $signed(velocity), height);
        end
      end
      if (i == 10) begin
        checks++;
        if (phase !== 2'd2) begin
          errors++; $display("FAIL start_in_coast: got phase %0d required 2", phase);
        end
      end
    end
    checks++;
    if (velocity !== '0 || height !== 64'd8800 || apogee !== APO_EN
        || apogee_height !== (APO_EN ? 64'd8800 : 64'd0)) begin
      errors++; $display("FAIL apogee: got v=%0d h=%0d apo=%0b apo_h=%0d required v=0 h=8800 apo=%0b apo_h=%0d",
                         velocity, height, apogee, apogee_height, APO_EN, APO_EN ? 8800 : 0);
    end
    for (int m = 1; m <= 42; m++) begin
      tick('0, 1'b0);
      if (apogee === 1'b1) apo_cnt++;
      checks++;
      if (obs !== model_word()) begin
        errors++; $display("FAIL descent_model %0d: got %h required %h", m, obs, model_word());
      end
      checks++;
      if (phase !== ((m == 42) ? 2'd3 : 2'd2)) begin
        errors++; $display("FAIL descent_phase %0d: got %0d required %0d", m, phase, (m == 42) ? 3 : 2);
      end
    end
    checks++;
    if (height !== '0 || velocity !== '0 || step !== 1'b1) begin
      errors++; $display("FAIL landing: got v=%0d h=%0d step=%0b required v=0 h=0 step=1",
                         velocity, height, step);
    end
    checks++;
    if (apo_cnt !== (APO_EN ? 1 : 0)) begin
      errors++; $display("FAIL apogee_count: got %0d required %0d", apo_cnt, APO_EN ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick('0, 1'b0);
      checks++;
      if (step !== 1'b0 || phase !== 2'd3 || obs !== model_word()) begin
        errors++; $display("FAIL landed_hold %0d: got %h required %h", i, obs, model_word());
      end
    end
  endtask

  task automatic test_pad_weak();
    tick('0, 1'b1);
    checks++;
    if (phase !== 2'd1 || velocity !== '0 || height !== '0 || apogee_height !== '0 || above_30km !== 1'b0) begin
      errors++; $display("FAIL restart: got %h required %h", obs, model_word());
    end
    for (int k = 1; k <= 4; k++) begin
      tick(64'd5, 1'b0);
      checks++;
      if (velocity !== '0 || height !== '0 || step !== 1'b1 || obs !== model_word()) begin
        errors++; $display("FAIL pad_weak %0d: got v=%0d h=%0d step=%0b required v=0 h=0 step=1",
                           k, velocity, height, step);
      end
    end
    tick('0, 1'b0);
    checks++;
    if (phase !== 2'd3 || height !== '0 || velocity !== '0 || obs !== model_word()) begin
      errors++; $display("FAIL pad_land: got %h required %h", obs, model_word());
    end
  endtask

  task automatic test_random_flight();
    int hi_tab[4] = '{15, 300, 2000, 60};
    logic [N-1:0] thr;
    for (int it = 0; it < 4; it++) begin
      tick('0, 1'b1);
      for (int c = 0; c < 6000 && m_phase != 3; c++) begin
        thr = N'($urandom_range(0, hi_tab[it]));
        tick(thr, $urandom_range(0, 7) == 0);
        checks++;
        if (obs !== model_word()) begin
          errors++; $display("FAIL random %0d cycle %0d: got %h required %h", it, c, obs, model_word());
        end
      end
      checks++;
      if (phase !== 2'd3) begin
        errors++; $display("FAIL random_landing %0d: got phase %0d required 3", it, phase);
      end
    end
  endtask

  task automatic test_30km();
    tick('0, 1'b1);
    for (int idx = 1; idx <= 12; idx++) begin
      tick((idx <= BC) ? 64'd1_000_000_000_010 : 64'd0, 1'b0);
      checks++;
      if (above_30km !== (idx >= 10)) begin
        errors++; $display("FAIL above_30km update %0d: got %0b required %0b", idx, above_30km, idx >= 10);
      end
      checks++;
      if (obs !== model_word()) begin
        errors++; $display("FAIL km30_model %0d: got %h required %h", idx, obs, model_word());
      end
    end
  endtask

  task automatic test_reset_midflight();
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_coast: got %h required 0", obs);
    end
    @(negedge clk);
    resetb = 1'b1;
    model_reset();
    tick('0, 1'b1);
    tick(64'd500, 1'b0);
    tick(64'd500, 1'b0);
    checks++;
    if (phase !== 2'd1 || velocity !== 64'd980 || obs !== model_word()) begin
      errors++; $display("FAIL pre_reset_burn: got %h required %h", obs, model_word());
    end
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_burn_async: got %h required 0", obs);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_burn_held: got %h required 0", obs);
    end
    @(negedge clk);
    resetb = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(64'd500, 1'b0);
      checks++;
      if (phase !== 2'd0 || obs !== model_word()) begin
        errors++; $display("FAIL post_reset_idle %0d: got %h required %h", i, obs, model_word());
      end
    end
    tick('0, 1'b1);
    checks++;
    if (phase !== 2'd1) begin
      errors++; $display("FAIL post_reset_start: got phase %0d required 1", phase);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_nominal();
    test_pad_weak();
    test_random_flight();
    test_30km();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascent_integrator.md
# ascent_integrator

- Upstream stage of the 30 km gimbal controller; produces the `velocity` and `height` words that the controller consumes.
- Each clock it integrates commanded thrust acceleration minus gravity into velocity, and velocity into height, in fixed point (1 LSB = 1e-9 m, time unit = 1 clock).
- A phase FSM sequences pad, burn, coast and landing.
- Also flags the 30 km crossing and, optionally, apogee.

## Interface
Parameters:
- `N`, 64, datapath width.
- `G_ACCEL`, 10, gravity decrement per clock, in LSB/clk².
- `BURN_CYCLES`, 1000, number of burn updates before engine cutoff.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `resetb`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: launch request; sampled only in IDLE or LANDED.
- `thrust_accel`, input, N: unsigned thrust acceleration, LSB/clk²; sampled every BURN cycle.
- `velocity`, output, N: signed two's-complement velocity, LSB/clk.
- `height`, output, N: unsigned height, LSB.
- `step`, output, 1: one-cycle pulse on every integration update.
- `phase`, output, 2: 0 IDLE, 1 BURN, 2 COAST, 3 LANDED.
- `above_30km`, output, 1: high while `height >= ALT_30KM`.
- `apogee`, output, 1: one-cycle apogee pulse.
- `apogee_height`, output, N: height captured at apogee.

## Operation
- IDLE: outputs hold. `start=1` → BURN; burn counter cleared; `velocity`/`height` cleared to 0.
- BURN, each cycle:
  - `v_next = v + thrust_accel - G_ACCEL`, signed, saturating at ±(2^(N-1)-1).
  - `h_next = h + v_next` (semi-implicit Euler).
  - If `h_next < 0` (still on pad): `h=0` and `v=0`; phase stays BURN.
  - Counter increments. The update where counter reaches `BURN_CYCLES` is the last burn update; phase becomes COAST.
- COAST, each cycle: `v_next = v - G_ACCEL`, `h_next = h + v_next`.
  - `h_next <= 0`: `h=0`, `v=0`, phase → LANDED.
  - `h_next` above 2^N-1: height saturates at all-ones.
- LANDED: outputs hold. `start=1` restarts exactly as from IDLE.
- `start` is ignored in BURN and COAST.
- `above_30km` is a registered compare against the new height, updated alongside it. `ALT_30KM = 30_000 * 10^9`.

## Timing
- Reset values: `velocity=0`, `height=0`, `phase=IDLE`, `step=0`, `above_30km=0`, `apogee=0`, `apogee_height=0`.
- `start` high in cycle T: `phase=BURN` at T+1, first `step`/update visible at T+2.
- `step` is high in every BURN and COAST update cycle, including the update that enters LANDED.
- Latency from `thrust_accel` to `velocity` is 1 clock. `height` reflects the same-cycle `v_next`.
- Reset asserted mid-flight: all outputs return to reset values immediately (asynchronous). After deassertion the FSM waits in IDLE for `start`.

## Configuration
- `ASCENT_APOGEE_EN` defined:
  - In COAST, when `v > 0` and `v_next <= 0`, `apogee` pulses with the update, and `apogee_height` loads `h_next`.
  - `apogee_height` holds until the next start or reset.
- Not defined: `apogee=0` and `apogee_height=0` at all times; no compare logic is synthesized.

## Structure
- Shared package `flight_pkg` holds:
  - the phase encoding constants;
  - `FX_SCALE = 10^9`;
  - `ALT_30KM`.
- The gimbal stage imports the same package.
- One sub-module, `sat_add`: N-bit signed adder with saturation, instantiated for the velocity and height paths.

## Test plan
- Nominal burn (`G_ACCEL=10`, `BURN_CYCLES=4`, `thrust_accel=110`, `start` pulse):
  - velocity 100, 200, 300, 400;
  - height 100, 300, 600, 1000;
  - phase becomes COAST after the 4th update.
- Same run continued into coast:
  - first coast update gives v=390, h=1390;
  - v reaches 0 after 40 coast updates with h=8800;
  - with `ASCENT_APOGEE_EN`: `apogee` pulses once there, `apogee_height=8800`.
- Descent from the same run: landing on the 42nd update after apogee → `height=0`, `velocity=0`, `phase=LANDED`, no further `step`.
- Weak thrust on pad (`thrust_accel=5`, `G_ACCEL=10`): height and velocity stay 0 throughout BURN; no underflow wrap.
- 30 km crossing: preload large thrust (`thrust_accel = 10^12 + 10`) → `above_30km` rises on the first update whose height is ≥ 3e13 and never earlier.
- Control edge cases:
  - `resetb` low mid-BURN → all outputs zero immediately;
  - `start` asserted during COAST → ignored;
  - `start` in LANDED → clean restart.
